// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory: size codes, FSM
// states, request decode (byte enables + error) and load-lane extraction.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic [3:0] be;
    logic       err;
  } dec_t;

  // Byte enables are only non-zero for a legal store; loads and errors write nothing.
  function automatic dec_t decode_req(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [2:0]  size,
                                      input int unsigned depth_words);
    dec_t d;
    d.be  = 4'b0000;
    d.err = 1'b0;
    case (size)
      SZ_B, SZ_BU: d.be = 4'b0001 << addr[1:0];
      SZ_H, SZ_HU: begin
        d.be  = addr[1] ? 4'b1100 : 4'b0011;
        d.err = addr[0];
      end
      SZ_W: begin
        d.be  = 4'b1111;
        d.err = (addr[1:0] != 2'b00);
      end
      default: d.err = 1'b1;
    endcase
    if (we && (size == SZ_BU || size == SZ_HU)) d.err = 1'b1;
    if ({2'b00, addr[31:2]} >= depth_words) d.err = 1'b1;
    if (d.err || !we) d.be = 4'b0000;
    return d;
  endfunction

  // Pick the addressed lane(s) out of a word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  size);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return {{24{b[7]}}, b};
      SZ_BU:   return {24'h000000, b};
      SZ_H:    return {{16{h[15]}}, h};
      SZ_HU:   return {16'h0000, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and registered read data.
// An enabled access with no byte enables is a read; read data holds otherwise.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write or synchronous read
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (be == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_pipe.sv
// Data memory with a valid/ready request port, one outstanding transaction and
// a fixed request-to-response latency. Stores commit at acceptance; loads read
// at acceptance and the RAM read register holds the word until the response
// is consumed, so extraction is applied on the way out.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  CntInit = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        err_q;
  logic        load_ok_q;
  logic [2:0]  size_q;
  logic [1:0]  lane_q;
  logic        accept;
  dec_t        dec;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  assign dec    = decode_req(req_we, req_addr, req_size, DEPTH_WORDS);
  assign accept = req_valid & req_ready_q & ~reset;

  // Replicate store data across lanes; byte enables pick the target lanes
  always_comb begin
    ram_wdata = req_wdata;
    case (req_size[1:0])
      2'b00:   ram_wdata = {4{req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{req_wdata[15:0]}};
      default: ram_wdata = req_wdata;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AddrW)
  ) u_array (
    .clk  (clk),
    .en   (accept),
    .be   (dec.be),
    .addr (req_addr[AddrW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_ok_q   <= 1'b0;
      size_q      <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            err_q       <= dec.err;
            load_ok_q   <= ~req_we & ~dec.err;
            size_q      <= req_size;
            lane_q      <= req_addr[1:0];
            if (LATENCY == 1) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 2'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_rdata = (rsp_valid_q & load_ok_q) ? extract(ram_rdata, lane_q, size_q) : 32'h0;

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench: dut0 runs with LATENCY=1, dut1 with LATENCY=3. Directed
// requests push expected responses; per-DUT monitors pop on each handshake.
module tb_dmem_pipe;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_size  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_pipe #(.DEPTH_WORDS(64), .LATENCY(1)) dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_pipe #(.DEPTH_WORDS(64), .LATENCY(3)) dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on each response handshake
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_unexpected_rsp: got rdata 0x%08h with no response expected",
                 rsp_rdata[0]);
      end else begin
        e = q0.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata[0], e.rdata);
        chk({e.name, "_err"}, 32'(rsp_err[0]), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_unexpected_rsp: got rdata 0x%08h with no response expected",
                 rsp_rdata[1]);
      end else begin
        e = q1.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata[1], e.rdata);
        chk({e.name, "_err"}, 32'(rsp_err[1]), 32'(e.err));
      end
    end
  end

  // Issue one request (called at posedge+1 with the DUT idle) and follow it through.
  // hold>0 keeps rsp_ready low for that many cycles once rsp_valid rises, while
  // presenting a stray store that must be ignored.
  task automatic do_req(input int d, input string name, input logic we,
                        input logic [31:0] a, input logic [31:0] w, input logic [2:0] sz,
                        input logic [31:0] er, input logic ee, input int lat, input int hold);
    exp_t e;
    int   cycles;
    e.rdata = er; e.err = ee; e.name = name;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    chk({name, "_ready_before"}, 32'(req_ready[d]), 32'd1);
    rsp_ready[d] = (hold == 0);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_wdata[d] = w; req_size[d] = sz;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h5A5A_5A5A; req_size[d] = 3'b111;
    cycles = 1;
    while (!rsp_valid[d] && cycles < 20) begin
      chk({name, "_ready_busy"}, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      cycles++;
    end
    chk({name, "_latency"}, 32'(cycles), 32'(lat));
    if (!rsp_valid[d]) return;
    if (hold > 0) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = a & 32'hFFFF_FFFC;
      req_wdata[d] = 32'h0; req_size[d] = 3'b010;
      for (int i = 0; i < hold; i++) begin
        chk({name, "_stall_valid"}, 32'(rsp_valid[d]), 32'd1);
        chk({name, "_stall_rdata"}, rsp_rdata[d], er);
        chk({name, "_stall_err"}, 32'(rsp_err[d]), 32'(ee));
        chk({name, "_stall_ready"}, 32'(req_ready[d]), 32'd0);
        @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, "_ready_after"}, 32'(req_ready[d]), 32'd1);
    chk({name, "_valid_after"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_size[d] = 3'b010; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
    end

    // LATENCY=1 functional vectors
    do_req(0, "sw_10", 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, 1, 0);
    do_req(0, "lw_10", 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, 1, 0);
    do_req(0, "sb_13", 1, 32'h13, 32'hAAAAAA80, 3'b000, 32'h0, 0, 1, 0);
    do_req(0, "lb_13", 0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 0, 1, 0);
    do_req(0, "lbu_13", 0, 32'h13, 32'h0, 3'b100, 32'h00000080, 0, 1, 0);
    do_req(0, "lw_10b", 0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1, 0);
    do_req(0, "lh_11_err", 0, 32'h11, 32'h0, 3'b001, 32'h0, 1, 1, 0);
    do_req(0, "sw_12_err", 1, 32'h12, 32'h12345678, 3'b010, 32'h0, 1, 1, 0);
    do_req(0, "lw_10c", 0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1, 0);
    do_req(0, "lw_100_err", 0, 32'h100, 32'h0, 3'b010, 32'h0, 1, 1, 0);
    do_req(0, "ld_sz011_err", 0, 32'h10, 32'h0, 3'b011, 32'h0, 1, 1, 0);
    do_req(0, "st_sz100_err", 1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1, 1, 0);
    do_req(0, "lw_10d", 0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1, 0);
    do_req(0, "sw_14", 1, 32'h14, 32'h0, 3'b010, 32'h0, 0, 1, 0);
    do_req(0, "sh_16", 1, 32'h16, 32'hFFFF8001, 3'b001, 32'h0, 0, 1, 0);
    do_req(0, "sb_14", 1, 32'h14, 32'h1234567F, 3'b000, 32'h0, 0, 1, 0);
    do_req(0, "lw_14", 0, 32'h14, 32'h0, 3'b010, 32'h8001007F, 0, 1, 0);
    do_req(0, "lh_16", 0, 32'h16, 32'h0, 3'b001, 32'hFFFF8001, 0, 1, 0);
    do_req(0, "lhu_16", 0, 32'h16, 32'h0, 3'b101, 32'h00008001, 0, 1, 0);
    do_req(0, "lb_14", 0, 32'h14, 32'h0, 3'b000, 32'h0000007F, 0, 1, 0);
    do_req(0, "sw_fc", 1, 32'hFC, 32'hA5A5A5A5, 3'b010, 32'h0, 0, 1, 0);
    do_req(0, "lw_fc", 0, 32'hFC, 32'h0, 3'b010, 32'hA5A5A5A5, 0, 1, 0);

    // A store presented during reset must not be accepted or written
    rst[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h11111111; req_size[0] = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; req_valid[0] = 1'b0;
    chk("rst_req_valid", 32'(rsp_valid[0]), 32'd0);
    do_req(0, "lw_10_postrst", 0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1, 0);

    // LATENCY=3 vectors, including a 5-cycle response stall
    do_req(1, "l3_sw_40", 1, 32'h40, 32'h13579BDF, 3'b010, 32'h0, 0, 3, 0);
    do_req(1, "l3_lw_40_stall", 0, 32'h40, 32'h0, 3'b010, 32'h13579BDF, 0, 3, 5);
    do_req(1, "l3_lw_40", 0, 32'h40, 32'h0, 3'b010, 32'h13579BDF, 0, 3, 0);

    // Reset one cycle after an accepted store: response dropped, store kept
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h0000ABCD; req_size[1] = 3'b001;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("l3_rst_req_ready", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("l3_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    do_req(1, "l3_lhu_20", 0, 32'h20, 32'h0, 3'b101, 32'h0000ABCD, 0, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit words (power of two, 16..4096).
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the cycles from request acceptance to response valid (range 1..4).
REQ-003 The block SHALL use one clock, clk, with a synchronous, active-high reset, reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: req_valid  in  1  request present.
REQ-007 Port: req_ready  out  1  block can accept a request.
REQ-008 Port: req_we  in  1  1=store, 0=load.
REQ-009 Port: req_addr  in  32  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-aligned.
REQ-011 Port: req_size  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 Port: rsp_valid  out  1  response present.
REQ-013 Port: rsp_ready  in  1  consumer accepts the response.
REQ-014 Port: rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 Port: rsp_err  out  1  misaligned, out-of-range or illegal size.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP, and SHALL allow one outstanding transaction.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge when req_valid and req_ready are both 1.
REQ-019 On acceptance, the next state SHALL be RESP if LATENCY=1, otherwise WAIT with a counter loaded to LATENCY-2.
REQ-020 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL move to RESP when the counter is 0, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-021 In RESP, rsp_valid=1, and rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1; the FSM then returns to IDLE, so req_ready=1 in the next cycle.
REQ-022 A store SHALL commit to the array at the acceptance edge using byte enables:
- B: one lane selected by addr[1:0], data from wdata[7:0];
- H: lanes {1,0} or {3,2} selected by addr[1], data from wdata[15:0];
- W: all four lanes.
REQ-023 A load SHALL sample the addressed word at the acceptance edge and register the extracted lane(s): B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-024 An error SHALL be flagged for any of these conditions, and an errored store SHALL write nothing:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- word index addr[31:2] >= DEPTH_WORDS;
- size 011, 110 or 111;
- store with size 100 or 101.
REQ-025 An errored request SHALL still be accepted and answered after LATENCY cycles with rsp_err=1 and rsp_rdata=0.
REQ-026 req_valid SHALL be ignored outside IDLE, and request inputs SHALL be don't-care when not accepted.
REQ-027 A load after a completed store to the same address SHALL return the stored value.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set the FSM to IDLE, clear the counter, and set rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready SHALL read 1 from the first cycle after reset deasserts.
REQ-029 A request presented while reset=1 SHALL NOT be accepted, and the array SHALL NOT be written.
REQ-030 Reset mid-transaction SHALL drop any pending response without emitting it; a store that was already accepted SHALL remain committed.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package dmem_pkg SHALL hold the size-code enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), the FSM state enum, and the function computing byte enables plus the error flag.
REQ-033 Sub-module dmem_array SHALL be a DEPTH_WORDS x 32 single-port RAM with 4-bit byte-write enable and synchronous read; dmem_pipe SHALL contain only the FSM, decode, extension and output registers.

Verification
REQ-034 LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp_err=0 and rsp_rdata=0; load rsp_rdata=0xDEADBEEF with rsp_valid exactly 1 cycle after acceptance.
REQ-035 SB 0x80 @0x13, then LB @0x13 and LBU @0x13 -> 0xFFFFFF80 and 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-036 The bench SHALL drive these error cases:
- LH @0x11 -> rsp_err=1, rsp_rdata=0;
- SW 0x12345678 @0x12 -> rsp_err=1, then LW @0x10 is unchanged;
- LW @0x100 (DEPTH_WORDS=64) -> rsp_err=1.
REQ-037 LATENCY=3, rsp_ready held 0 for 5 cycles:
- rsp_valid SHALL rise 3 cycles after acceptance;
- data SHALL stay stable while rsp_ready=0;
- req_ready SHALL be 0 throughout;
- req_ready SHALL be 1 the cycle after rsp_ready=1.
REQ-038 LATENCY=3, reset asserted 1 cycle after SH 0xABCD @0x20 is accepted:
- no rsp_valid SHALL appear;
- after reset, LHU @0x20 -> 0x0000ABCD.
